// File: rtl/fp_scan_sequencer.sv
// Front-panel LED matrix scan sequencer: blank gap + dwell per group, frame-coherent lamp snapshot.
// Optional PWM dimming of the column drive is enabled by defining FP_DIM_EN.
module fp_scan_sequencer #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [11:0] green,
  input  logic [11:0] red,
  input  logic [11:0] yellow,
  input  logic        lamp_test,
`ifdef FP_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic [5:0]  grp_en,
  output logic [5:0]  pled,
  output logic        frame_start
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_group, w_group_nxt, w_grp_safe;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [35:0]        r_snap, w_snap_nxt;
  logic               r_lt, w_lt_nxt;
  logic [5:0]         r_grp_en, w_grp_en_nxt;
  logic [5:0]         r_pled, w_pled_nxt;
  logic [5:0]         w_slice;
  logic               w_frame_edge;
`ifdef FP_DIM_EN
  logic [2:0]         r_bright, w_bright_nxt;
  logic [31:0]        w_on_len;
`endif

  // Next-state, snapshot and output pre-decode; outputs are registered from the next state
  always_comb begin
    w_grp_safe   = (r_group > 3'd5) ? 3'd0 : r_group;
    w_frame_edge = (r_state == S_BLANK) && (w_grp_safe == 3'd0) && (r_cnt == '0);
    w_state_nxt  = r_state;
    w_group_nxt  = w_grp_safe;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_snap_nxt   = r_snap;
    w_lt_nxt     = r_lt;
    w_grp_en_nxt = 6'd0;
    w_pled_nxt   = 6'd0;
    w_slice      = 6'd0;
`ifdef FP_DIM_EN
    w_bright_nxt = r_bright;
    w_on_len     = 32'd0;
`endif

    case (r_state)
      S_BLANK: begin
        if (r_cnt == CNT_W'(BLANK - 1)) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      S_DRIVE: begin
        if (r_cnt == CNT_W'(DWELL - 1)) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_group_nxt = (w_grp_safe == 3'd5) ? 3'd0 : w_grp_safe + 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_BLANK;
        w_cnt_nxt   = '0;
        w_group_nxt = 3'd0;
      end
    endcase

    if (w_frame_edge) begin
      w_snap_nxt   = {yellow, red, green};
      w_lt_nxt     = lamp_test;
`ifdef FP_DIM_EN
      w_bright_nxt = brightness;
`endif
    end

    // Slice uses the post-edge snapshot so a one-cycle blank still drives fresh data
    case (w_group_nxt)
      3'd0:    w_slice = w_snap_nxt[5:0];
      3'd1:    w_slice = w_snap_nxt[11:6];
      3'd2:    w_slice = w_snap_nxt[17:12];
      3'd3:    w_slice = w_snap_nxt[23:18];
      3'd4:    w_slice = w_snap_nxt[29:24];
      3'd5:    w_slice = w_snap_nxt[35:30];
      default: w_slice = 6'd0;
    endcase
    if (w_lt_nxt) w_slice = 6'h3F;

    if (w_state_nxt == S_DRIVE) begin
      w_grp_en_nxt = 6'(6'd1 << w_group_nxt);
      w_pled_nxt   = w_slice;
`ifdef FP_DIM_EN
      w_on_len     = ((32'(w_bright_nxt) + 32'd1) * 32'(DWELL)) >> 3;
      if (!(32'(w_cnt_nxt) < w_on_len)) w_pled_nxt = 6'd0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= S_BLANK;
      r_group  <= 3'd0;
      r_cnt    <= '0;
      r_snap   <= 36'd0;
      r_lt     <= 1'b0;
      r_grp_en <= 6'd0;
      r_pled   <= 6'd0;
`ifdef FP_DIM_EN
      r_bright <= 3'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_group  <= w_group_nxt;
      r_cnt    <= w_cnt_nxt;
      r_snap   <= w_snap_nxt;
      r_lt     <= w_lt_nxt;
      r_grp_en <= w_grp_en_nxt;
      r_pled   <= w_pled_nxt;
`ifdef FP_DIM_EN
      r_bright <= w_bright_nxt;
`endif
    end
  end

  assign grp_en      = r_grp_en;
  assign pled        = r_pled;
  // Pulse marks the cycle whose closing edge takes the snapshot; held low while in reset
  assign frame_start = nRESET & w_frame_edge;

endmodule

// File: tb/tb_fp_scan_sequencer.sv
// Randomized bench for fp_scan_sequencer against a frame-position reference model.
// Define FP_DIM_EN to exercise the brightness-gated build.
module tb_fp_scan_sequencer;

  localparam int unsigned BLANK = 2;
`ifdef FP_DIM_EN
  localparam int unsigned DWELL = 8;
`else
  localparam int unsigned DWELL = 4;
`endif
  localparam int unsigned SLOT  = BLANK + DWELL;
  localparam int unsigned FRAME = 6 * SLOT;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [11:0] green, red, yellow;
  logic        lamp_test;
  logic [2:0]  brightness;
  logic [5:0]  grp_en, pled;
  logic        frame_start;

  fp_scan_sequencer #(.DWELL(DWELL), .BLANK(BLANK)) u_dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .green      (green),
    .red        (red),
    .yellow     (yellow),
    .lamp_test  (lamp_test),
`ifdef FP_DIM_EN
    .brightness (brightness),
`endif
    .grp_en     (grp_en),
    .pled       (pled),
    .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  int          t;
  logic [35:0] m_snap;
  logic        m_lt;
  logic [2:0]  m_bright;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // Expected outputs from the position within the frame, t cycles after reset release
  task automatic check_cycle();
    int unsigned p, g, off, on_len;
    logic [5:0]  e_grp, e_pled;
    p      = t % FRAME;
    g      = p / SLOT;
    off    = p % SLOT;
    e_grp  = 6'd0;
    e_pled = 6'd0;
    if (off >= BLANK) begin
      e_grp  = 6'(1 << g);
      e_pled = m_lt ? 6'h3F : m_snap[6*g +: 6];
`ifdef FP_DIM_EN
      on_len = ((m_bright + 1) * DWELL) / 8;
      if ((off - BLANK) >= on_len) e_pled = 6'd0;
`else
      on_len = DWELL;
`endif
    end
    check("frame_start", 32'(frame_start), 32'(p == 0));
    check("grp_en", 32'(grp_en), 32'(e_grp));
    check("pled", 32'(pled), 32'(e_pled));
  endtask

  task automatic drive_inputs();
    green      = 12'($urandom);
    red        = 12'($urandom);
    yellow     = 12'($urandom);
    lamp_test  = ($urandom_range(0, 5) == 0);
    brightness = 3'($urandom);
    if ((t % FRAME) == 0) begin
      m_snap   = {yellow, red, green};
      m_lt     = lamp_test;
      m_bright = brightness;
    end
  endtask

  // Called at a falling edge: check, stimulate, advance one cycle
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check_cycle();
      drive_inputs();
      @(negedge CLK);
      t++;
    end
  endtask

  task automatic release_reset();
    @(negedge CLK);
    nRESET = 1'b1;
    t      = 0;
  endtask

  initial begin
    int unsigned p;
    int          guard;
    nRESET = 1'b0;
    green = '0; red = '0; yellow = '0; lamp_test = 1'b0; brightness = '0;
    m_snap = '0; m_lt = 1'b0; m_bright = '0;
    t = 0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_grp_en", 32'(grp_en), 32'd0);
    check("rst_pled", 32'(pled), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);

    release_reset();
    run_cycles(4 * FRAME);

    // Walk to the drive phase of group 4, then pull reset between edges
    guard = 0;
    p = t % FRAME;
    while (!((p / SLOT) == 4 && (p % SLOT) >= BLANK) && guard < int'(FRAME)) begin
      run_cycles(1);
      p = t % FRAME;
      guard++;
    end
    check("reach_group4", 32'(guard < int'(FRAME)), 32'd1);
    #2;
    check("pre_async_grp_en", 32'(grp_en), 32'h10);
    nRESET = 1'b0;
    #1;
    check("async_grp_en", 32'(grp_en), 32'd0);
    check("async_pled", 32'(pled), 32'd0);
    check("async_frame_start", 32'(frame_start), 32'd0);
    repeat (2) @(negedge CLK);
    release_reset();
    run_cycles(3 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
